tap_loader: RTL and testbench

Parametrised Lynx `.TAP` loader that parses a cassette image streamed over the MiSTer ioctl download port and writes payload bytes into system RAM through a ready/ack write port. It supports multi-block files and file types B, M, D and A. It also provides checksum verification, error reporting and ioctl back-pressure. It sits between hps_io and the RAM arbiter and hands the final execution address to the CPU boot logic.

---
 rtl/tap_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_tap_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_loader.sv
// Lynx .TAP cassette image loader: parses the ioctl download stream and writes
// block payloads into RAM through a held-until-ack write port.
module tap_loader #(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       IOCTL_AW   = 25,
    parameter logic [ADDR_W-1:0] BASIC_BASE = 16'h694D,
    parameter int unsigned       NAME_MAX   = 16,
    parameter bit                CHECK_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                ioctl_wait,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_dout,
    input  logic                mem_ack,
    output logic [ADDR_W-1:0]   exec_addr,
    output logic [7:0]          file_type,
    output logic [3:0]          blk_count,
    output logic                done,
    output logic                error,
    output logic [2:0]          err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_NAME, S_TYPE, S_LEN_LO, S_LEN_HI, S_LOAD_LO, S_LOAD_HI,
        S_DATA, S_CHECK, S_EXEC_LO, S_EXEC_HI, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        E_NONE, E_TRUNC, E_TYPE, E_CHK, E_NAME, E_OVERRUN
    } err_t;

    localparam logic [7:0] QUOTE = 8'h22;
    localparam logic [7:0] FILL  = 8'hA5;
    localparam logic [7:0] T_A   = 8'h41;
    localparam logic [7:0] T_B   = 8'h42;
    localparam logic [7:0] T_D   = 8'h44;
    localparam logic [7:0] T_M   = 8'h4D;

    localparam int unsigned      NAME_W   = $clog2(NAME_MAX + 1);
    localparam logic [NAME_W-1:0] NAME_LIM = NAME_W'(NAME_MAX);

    state_t              state, state_n;
    logic                dl_q;
    logic [NAME_W-1:0]   name_cnt;
    logic [7:0]          typ;
    logic [7:0]          lo_byte;
    logic [15:0]         len;
    logic [ADDR_W-1:0]   ptr;
    logic [7:0]          sum;
    logic                done_pend;

    logic dl_rise, dl_fall, byte_in, overrun;
    logic start, name_inc, typ_ld, lo_ld, len_ld, ptr_base, ptr_load;
    logic wr_req, exec_ld, blk_done, err_req;
    err_t err_val;

    logic unused_ok;
    assign unused_ok = ^ioctl_addr;

    assign ioctl_wait = mem_wr;
    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    // The rise cycle only clears state; bytes count from the following cycle.
    assign byte_in    = ioctl_download & dl_q & ioctl_wr & ~ioctl_wait;
    assign overrun    = ioctl_download & dl_q & ioctl_wr & ioctl_wait;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        name_inc = 1'b0;
        typ_ld   = 1'b0;
        lo_ld    = 1'b0;
        len_ld   = 1'b0;
        ptr_base = 1'b0;
        ptr_load = 1'b0;
        wr_req   = 1'b0;
        exec_ld  = 1'b0;
        blk_done = 1'b0;
        err_req  = 1'b0;
        err_val  = E_NONE;
        if (dl_rise) begin
            state_n = S_IDLE;
        end else if (dl_fall) begin
            if (state != S_IDLE || blk_count == 4'd0) begin
                err_req = 1'b1;
                err_val = E_TRUNC;
            end
        end else if (overrun) begin
            err_req = 1'b1;
            err_val = E_OVERRUN;
        end else if (byte_in) begin
            unique case (state)
                S_IDLE: if (ioctl_dout == QUOTE) begin
                    start   = 1'b1;
                    state_n = S_NAME;
                end
                S_NAME: begin
                    if (ioctl_dout == QUOTE) state_n = S_TYPE;
                    else if (name_cnt == NAME_LIM) begin
                        err_req = 1'b1;
                        err_val = E_NAME;
                    end else name_inc = 1'b1;
                end
                S_TYPE: begin
                    if (ioctl_dout == FILL) state_n = S_TYPE;
                    else if (ioctl_dout == T_A || ioctl_dout == T_B ||
                             ioctl_dout == T_D || ioctl_dout == T_M) begin
                        typ_ld  = 1'b1;
                        state_n = S_LEN_LO;
                    end else begin
                        err_req = 1'b1;
                        err_val = E_TYPE;
                    end
                end
                S_LEN_LO: begin
                    lo_ld   = 1'b1;
                    state_n = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_ld = 1'b1;
                    if (typ == T_M || typ == T_D) state_n = S_LOAD_LO;
                    else begin
                        ptr_base = 1'b1;
                        state_n  = ({ioctl_dout, lo_byte} == 16'd0) ? S_CHECK : S_DATA;
                    end
                end
                S_LOAD_LO: begin
                    lo_ld   = 1'b1;
                    state_n = S_LOAD_HI;
                end
                S_LOAD_HI: begin
                    ptr_load = 1'b1;
                    state_n  = (len == 16'd0) ? S_CHECK : S_DATA;
                end
                S_DATA: begin
                    wr_req = 1'b1;
                    if (len == 16'd1) state_n = S_CHECK;
                end
                S_CHECK: begin
                    if (CHECK_EN && ioctl_dout != sum) begin
                        err_req = 1'b1;
                        err_val = E_CHK;
                    end else if (typ == T_M) state_n = S_EXEC_LO;
                    else begin
                        blk_done = 1'b1;
                        state_n  = S_IDLE;
                    end
                end
                S_EXEC_LO: begin
                    lo_ld   = 1'b1;
                    state_n = S_EXEC_HI;
                end
                S_EXEC_HI: begin
                    exec_ld  = 1'b1;
                    blk_done = 1'b1;
                    state_n  = S_IDLE;
                end
                S_ERR: state_n = S_ERR;
                default: state_n = S_IDLE;
            endcase
        end
        if (err_req) state_n = S_ERR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_q      <= 1'b0;
            name_cnt  <= '0;
            typ       <= '0;
            lo_byte   <= '0;
            len       <= '0;
            ptr       <= '0;
            sum       <= '0;
            done_pend <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_dout  <= '0;
            exec_addr <= BASIC_BASE;
            file_type <= '0;
            blk_count <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= '0;
        end else begin
            dl_q <= ioctl_download;
            done <= 1'b0;
            if (mem_wr && mem_ack) mem_wr <= 1'b0;

            if (dl_rise) begin
                error     <= 1'b0;
                err_code  <= '0;
                blk_count <= '0;
                exec_addr <= BASIC_BASE;
                done_pend <= 1'b0;
            end

            // done waits for any outstanding write to be acknowledged
            if (dl_fall || done_pend) begin
                if (!mem_wr || mem_ack) begin
                    done      <= 1'b1;
                    done_pend <= 1'b0;
                end else begin
                    done_pend <= 1'b1;
                end
            end

            if (start) begin
                name_cnt <= '0;
                sum      <= '0;
            end
            if (name_inc) name_cnt <= name_cnt + 1'b1;
            if (typ_ld)   typ      <= ioctl_dout;
            if (lo_ld)    lo_byte  <= ioctl_dout;
            if (len_ld)   len      <= {ioctl_dout, lo_byte};
            if (ptr_base) ptr      <= BASIC_BASE;
            if (ptr_load) ptr      <= ADDR_W'({ioctl_dout, lo_byte});
            if (wr_req) begin
                mem_wr   <= 1'b1;
                mem_addr <= ptr;
                mem_dout <= ioctl_dout;
                ptr      <= ptr + 1'b1;
                sum      <= sum + ioctl_dout;
                len      <= len - 16'd1;
            end
            if (exec_ld) exec_addr <= ADDR_W'({ioctl_dout, lo_byte});
            if (blk_done) begin
                file_type <= typ;
                if (blk_count != 4'hF) blk_count <= blk_count + 4'd1;
            end
            if (err_req && !error) begin
                error    <= 1'b1;
                err_code <= err_val;
            end
        end
    end

endmodule

// File: tb/tb_tap_loader.sv
// Scoreboard bench for tap_loader: stimulus pushes expected RAM writes and done
// results; a monitor pops and compares them as the DUT presents them.
module tb_tap_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;
    typedef struct packed {
        logic        err;
        logic [2:0]  code;
        logic [3:0]  blk;
        logic [15:0] exec;
        logic [7:0]  ftype;
    } done_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        mem_ack;

    logic        ioctl_wait, mem_wr, done, error;
    logic [15:0] mem_addr, exec_addr;
    logic [7:0]  mem_dout, file_type;
    logic [3:0]  blk_count;
    logic [2:0]  err_code;

    logic        d1_wait, d1_mem_wr, d1_done, d1_error;
    logic [15:0] d1_mem_addr, d1_exec_addr;
    logic [7:0]  d1_mem_dout, d1_file_type;
    logic [3:0]  d1_blk_count;
    logic [2:0]  d1_err_code;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_seen    = 0;
    int wait_run     = 0;
    int wait_runs    = 0;
    bit chk_wait     = 1'b0;
    int unsigned ack_delay = 0;

    wr_t   wr_q[$];
    done_t done_q[$];

    always #5 clk = ~clk;

    tap_loader #(.CHECK_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_ack(mem_ack),
        .exec_addr(exec_addr), .file_type(file_type), .blk_count(blk_count),
        .done(done), .error(error), .err_code(err_code)
    );

    tap_loader #(.CHECK_EN(1'b0)) dut_nochk (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(d1_wait),
        .mem_wr(d1_mem_wr), .mem_addr(d1_mem_addr), .mem_dout(d1_mem_dout), .mem_ack(mem_ack),
        .exec_addr(d1_exec_addr), .file_type(d1_file_type), .blk_count(d1_blk_count),
        .done(d1_done), .error(d1_error), .err_code(d1_err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model: ack tied high, or ack after mem_wr has been up ack_delay cycles
    initial begin
        int unsigned cnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_delay == 0) mem_ack = 1'b1;
            else if (mem_wr && !mem_ack) begin
                if (cnt == ack_delay) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                end else cnt++;
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        wr_t   ew;
        done_t ed;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_wr && mem_ack) begin
                    if (wr_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_write: got %h=%h expected none", mem_addr, mem_dout);
                    end else begin
                        ew = wr_q.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(ew.addr));
                        check("wr_data", 32'(mem_dout), 32'(ew.data));
                    end
                end
                if (done) begin
                    done_seen++;
                    if (done_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_done: got done expected none");
                    end else begin
                        ed = done_q.pop_front();
                        check("done_writes_drained", 32'(wr_q.size()), 32'd0);
                        check("done_error", 32'(error), 32'(ed.err));
                        check("done_err_code", 32'(err_code), 32'(ed.code));
                        check("done_blk_count", 32'(blk_count), 32'(ed.blk));
                        check("done_exec_addr", 32'(exec_addr), 32'(ed.exec));
                        check("done_file_type", 32'(file_type), 32'(ed.ftype));
                    end
                end
                if (ioctl_wait) wait_run++;
                else if (wait_run != 0) begin
                    if (chk_wait) begin
                        check("wait_len", 32'(wait_run), 32'd4);
                        wait_runs++;
                    end
                    wait_run = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int unsigned guard = 0;
        while (ioctl_wait | d1_wait) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                check("wait_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(posedge clk);
        #1;
        ioctl_wr   = 1'b0;
        ioctl_addr = ioctl_addr + 25'd1;
    endtask

    task automatic send_seq(input byte_q_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        ioctl_addr     = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic end_dl(input done_t exp);
        int target;
        int unsigned guard = 0;
        done_q.push_back(exp);
        target = done_seen + 1;
        ioctl_download = 1'b0;
        while (done_seen < target && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (done_seen < target) check("done_timeout", 32'(done_seen), 32'(target));
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic wr_t w(input logic [15:0] a, input logic [7:0] d);
        w.addr = a;
        w.data = d;
    endfunction

    function automatic done_t dn(input logic e, input logic [2:0] c, input logic [3:0] b,
                                 input logic [15:0] x, input logic [7:0] t);
        dn.err = e; dn.code = c; dn.blk = b; dn.exec = x; dn.ftype = t;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t seq;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        check("rst_done_error", 32'({done, error}), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_blk_count", 32'(blk_count), 32'd0);
        check("rst_file_type", 32'(file_type), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_exec_addr", 32'(exec_addr), 32'h694D);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // M block, ack tied high
        wr_q.push_back(w(16'h8000, 8'h01));
        wr_q.push_back(w(16'h8001, 8'h02));
        wr_q.push_back(w(16'h8002, 8'h03));
        start_dl();
        seq = '{8'h22, 8'h41, 8'h42, 8'h22, 8'h4D, 8'h03, 8'h00, 8'h00, 8'h80,
                8'h01, 8'h02, 8'h03, 8'h06, 8'h02, 8'h80};
        send_seq(seq);
        end_dl(dn(1'b0, 3'd0, 4'd1, 16'h8002, 8'h4D));

        // B block with A5 fill before the type byte
        wr_q.push_back(w(16'h694D, 8'hAA));
        wr_q.push_back(w(16'h694E, 8'h55));
        start_dl();
        seq = '{8'h22, 8'h58, 8'h22, 8'hA5, 8'hA5, 8'h42, 8'h02, 8'h00, 8'hAA, 8'h55, 8'hFF};
        send_seq(seq);
        end_dl(dn(1'b0, 3'd0, 4'd1, 16'h694D, 8'h42));

        // D block wrapping past FFFF
        wr_q.push_back(w(16'hFFFF, 8'h11));
        wr_q.push_back(w(16'h0000, 8'h22));
        start_dl();
        seq = '{8'h22, 8'h44, 8'h22, 8'h44, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33};
        send_seq(seq);
        end_dl(dn(1'b0, 3'd0, 4'd1, 16'h694D, 8'h44));

        // bad checksum, then a B block the checking instance must ignore
        wr_q.push_back(w(16'h4000, 8'h10));
        wr_q.push_back(w(16'h4001, 8'h20));
        start_dl();
        seq = '{8'h22, 8'h44, 8'h22, 8'h44, 8'h02, 8'h00, 8'h00, 8'h40, 8'h10, 8'h20, 8'h31,
                8'h22, 8'h22, 8'h42, 8'h01, 8'h00, 8'h7E, 8'h7E};
        send_seq(seq);
        end_dl(dn(1'b1, 3'd3, 4'd0, 16'h694D, 8'h44));
        check("nochk_error", 32'(d1_error), 32'd0);
        check("nochk_err_code", 32'(d1_err_code), 32'd0);
        check("nochk_blk_count", 32'(d1_blk_count), 32'd2);
        check("nochk_file_type", 32'(d1_file_type), 32'h42);

        // D then M with ack delayed 3 cycles
        ack_delay = 3;
        repeat (2) @(posedge clk);
        #1;
        chk_wait  = 1'b1;
        wait_runs = 0;
        wr_q.push_back(w(16'h9000, 8'hA1));
        wr_q.push_back(w(16'h9001, 8'hA2));
        wr_q.push_back(w(16'hA000, 8'h5A));
        start_dl();
        seq = '{8'h22, 8'h31, 8'h22, 8'h44, 8'h02, 8'h00, 8'h00, 8'h90, 8'hA1, 8'hA2, 8'h43,
                8'h22, 8'h32, 8'h22, 8'h4D, 8'h01, 8'h00, 8'h00, 8'hA0, 8'h5A, 8'h5A, 8'h34, 8'h12};
        send_seq(seq);
        end_dl(dn(1'b0, 3'd0, 4'd2, 16'h1234, 8'h4D));
        chk_wait = 1'b0;
        check("wait_runs", 32'(wait_runs), 32'd3);
        ack_delay = 0;
        repeat (2) @(posedge clk);
        #1;

        // truncated after 1 of 3 payload bytes, download drops with write pending
        wr_q.push_back(w(16'h7000, 8'hEE));
        start_dl();
        seq = '{8'h22, 8'h54, 8'h22, 8'h4D, 8'h03, 8'h00, 8'h00, 8'h70, 8'hEE};
        send_seq(seq);
        end_dl(dn(1'b1, 3'd1, 4'd0, 16'h694D, 8'h4D));

        // overrun: strobe while ioctl_wait is high, byte must be dropped
        wr_q.push_back(w(16'h6000, 8'hC3));
        start_dl();
        seq = '{8'h22, 8'h4F, 8'h22, 8'h44, 8'h03, 8'h00, 8'h00, 8'h60, 8'hC3};
        send_seq(seq);
        check("wait_at_overrun", 32'(ioctl_wait), 32'd1);
        ioctl_wr   = 1'b1;
        ioctl_dout = 8'h99;
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        end_dl(dn(1'b1, 3'd5, 4'd0, 16'h694D, 8'h4D));

        check("final_wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("final_done_q_empty", 32'(done_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
